// File: rtl/vga_frame_checker.sv
// Frame checker for a VGA pixel stream: validates raster order and coordinate range and
// reports per-frame pixel count and rotate-XOR checksum. Define FRAME_CHECK_WHITE_CNT_EN to build the white-pixel counter.
module vga_frame_checker #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    output logic        frame_valid,
    output logic [19:0] pix_cnt,
    output logic [15:0] checksum,
    output logic        err_seq,
    output logic        err_range,
    output logic        err_short,
    output logic [19:0] white_cnt
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        CAPTURE    = 2'd1,
        REPORT     = 2'd2
    } state_t;

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);

    state_t      state_q;
    logic        inValid_q;
    logic [10:0] vcount_q, hcount_q;
    logic        vsync_q, vblnk_q, hsync_q, hblnk_q;
    logic [11:0] rgb_q;
    logic        vblnkPrev_q;
    logic [10:0] prevH_q, prevV_q;
    logic [19:0] pixAcc_q;
    logic [15:0] chkAcc_q;
    logic        errSeqAcc_q, errRangeAcc_q;
    logic        frameValid_q;
    logic [19:0] pixCnt_q;
    logic [15:0] checksum_q;
    logic        errSeq_q, errRange_q, errShort_q;

    logic        activePix, atOrigin, atLast, vblnkRise;
    logic        seqBad, rangeBad, accept, finish, shortEnd;
    logic [19:0] pixAcc_d;
    logic [15:0] chkAcc_d;
    logic        errSeqAcc_d, errRangeAcc_d;

    // inValid_q masks the all-zero input stage right after reset, which would otherwise look like pixel (0,0).
    assign activePix = inValid_q && !vblnk_q && !hblnk_q;
    assign atOrigin  = activePix && (hcount_q == 11'd0) && (vcount_q == 11'd0);
    assign atLast    = activePix && (hcount_q == H_LAST) && (vcount_q == V_LAST);
    assign vblnkRise = inValid_q && vblnk_q && !vblnkPrev_q;

    assign seqBad = atOrigin ||
                    !(((hcount_q == prevH_q + 11'd1) && (vcount_q == prevV_q)) ||
                      ((hcount_q == 11'd0) && (vcount_q == prevV_q + 11'd1)));
    assign rangeBad = ({1'b0, hcount_q} >= H_LIM) || ({1'b0, vcount_q} >= V_LIM);

    assign accept   = activePix && (((state_q == WAIT_FRAME) && atOrigin) || (state_q == CAPTURE));
    assign finish   = accept && atLast;
    assign shortEnd = (state_q == CAPTURE) && vblnkRise;

    assign pixAcc_d      = (pixAcc_q == 20'hFFFFF) ? pixAcc_q : pixAcc_q + 20'd1;
    assign chkAcc_d      = {chkAcc_q[14:0], chkAcc_q[15]} ^ {4'h0, rgb_q};
    assign errSeqAcc_d   = errSeqAcc_q | ((state_q == CAPTURE) && seqBad);
    assign errRangeAcc_d = errRangeAcc_q | rangeBad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_FRAME;
            inValid_q     <= 1'b0;
            vcount_q      <= '0;
            hcount_q      <= '0;
            vsync_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            hsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            rgb_q         <= '0;
            vblnkPrev_q   <= 1'b0;
            prevH_q       <= '0;
            prevV_q       <= '0;
            pixAcc_q      <= '0;
            chkAcc_q      <= '0;
            errSeqAcc_q   <= 1'b0;
            errRangeAcc_q <= 1'b0;
            frameValid_q  <= 1'b0;
            pixCnt_q      <= '0;
            checksum_q    <= '0;
            errSeq_q      <= 1'b0;
            errRange_q    <= 1'b0;
            errShort_q    <= 1'b0;
        end else begin
            vcount_q     <= vcount_in;
            hcount_q     <= hcount_in;
            vsync_q      <= vsync_in;
            vblnk_q      <= vblnk_in;
            hsync_q      <= hsync_in;
            hblnk_q      <= hblnk_in;
            rgb_q        <= rgb_in;
            inValid_q    <= 1'b1;
            vblnkPrev_q  <= vblnk_q;
            frameValid_q <= 1'b0;

            if (accept) begin
                pixAcc_q      <= pixAcc_d;
                chkAcc_q      <= chkAcc_d;
                errSeqAcc_q   <= errSeqAcc_d;
                errRangeAcc_q <= errRangeAcc_d;
                prevH_q       <= hcount_q;
                prevV_q       <= vcount_q;
            end

            case (state_q)
                WAIT_FRAME: begin
                    if (finish)      state_q <= REPORT;
                    else if (accept) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (finish || shortEnd) state_q <= REPORT;
                end
                REPORT: begin
                    pixAcc_q      <= '0;
                    chkAcc_q      <= '0;
                    errSeqAcc_q   <= 1'b0;
                    errRangeAcc_q <= 1'b0;
                    state_q       <= WAIT_FRAME;
                end
                default: state_q <= WAIT_FRAME;
            endcase

            // Outputs load on entry to REPORT so frame_valid is high during the REPORT cycle itself.
            if (finish || shortEnd) begin
                frameValid_q <= 1'b1;
                pixCnt_q     <= finish ? pixAcc_d : pixAcc_q;
                checksum_q   <= finish ? chkAcc_d : chkAcc_q;
                errSeq_q     <= finish ? errSeqAcc_d : errSeqAcc_q;
                errRange_q   <= finish ? errRangeAcc_d : errRangeAcc_q;
                errShort_q   <= shortEnd && !finish;
            end
        end
    end

    assign frame_valid = frameValid_q;
    assign pix_cnt     = pixCnt_q;
    assign checksum    = checksum_q;
    assign err_seq     = errSeq_q;
    assign err_range   = errRange_q;
    assign err_short   = errShort_q;

`ifdef FRAME_CHECK_WHITE_CNT_EN
    logic [19:0] whiteAcc_q, whiteCnt_q, whiteAcc_d;

    assign whiteAcc_d = ((rgb_q == 12'hfff) && (whiteAcc_q != 20'hFFFFF)) ? whiteAcc_q + 20'd1 : whiteAcc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            whiteAcc_q <= '0;
            whiteCnt_q <= '0;
        end else begin
            if (state_q == REPORT) whiteAcc_q <= '0;
            else if (accept)       whiteAcc_q <= whiteAcc_d;
            if (finish)        whiteCnt_q <= whiteAcc_d;
            else if (shortEnd) whiteCnt_q <= whiteAcc_q;
        end
    end

    assign white_cnt = whiteCnt_q;
`else
    assign white_cnt = 20'd0;
`endif

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed testbench for vga_frame_checker on a scaled 8x4 raster with short blanking.
// Expected white_cnt follows FRAME_CHECK_WHITE_CNT_EN.
module tb_vga_frame_checker;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int HBL = 3;
    localparam int VBL = 3;
`ifdef FRAME_CHECK_WHITE_CNT_EN
    localparam int WHITE_EN = 1;
`else
    localparam int WHITE_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] rgb_in;
    logic        frame_valid;
    logic [19:0] pix_cnt;
    logic [15:0] checksum;
    logic        err_seq, err_range, err_short;
    logic [19:0] white_cnt;

    always #5 clk = ~clk;

    vga_frame_checker #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk        (clk),
        .rst        (rst),
        .vcount_in  (vcount_in),
        .hcount_in  (hcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .rgb_in     (rgb_in),
        .frame_valid(frame_valid),
        .pix_cnt    (pix_cnt),
        .checksum   (checksum),
        .err_seq    (err_seq),
        .err_range  (err_range),
        .err_short  (err_short),
        .white_cnt  (white_cnt)
    );

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;
    int fvCount = 0;
    int fvCycle = -1;
    int fvBefore = 0;
    int lastPixCycle = 0;
    logic [19:0] seenPix;

    int skipV, skipH, activeLines, whiteN, rgbInc, extraH, rstV, rstH, originLine;
    logic [15:0] expChk;

    always @(posedge clk) cycleCount++;

    always @(negedge clk) begin
        if (frame_valid) begin
            fvCount++;
            fvCycle = cycleCount;
            seenPix = pix_cnt;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setDefaults();
        skipV = -1; skipH = -1; activeLines = V; whiteN = 0; rgbInc = 0;
        extraH = 0; rstV = -1; rstH = -1; originLine = -1;
    endtask

    task automatic drivePixel(input int h, input int v, input logic vb, input logic hb,
                              input logic [11:0] c, input logic r);
        @(posedge clk);
        #1;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        vblnk_in  = vb;
        hblnk_in  = hb;
        vsync_in  = vb;
        hsync_in  = hb;
        rgb_in    = c;
        rst       = r;
    endtask

    // Drives one raster frame; expChk tracks the rotate-XOR checksum of the active pixels actually driven.
    task automatic applyStimulus();
        int n;
        int lineW;
        int vDrawn;
        logic vb, hb;
        logic [11:0] color;
        n = 0;
        expChk = 16'h0000;
        fvBefore = fvCount;
        for (int v = 0; v < V + VBL; v++) begin
            lineW = (v == 0 && extraH != 0) ? H + 1 : H;
            for (int h = 0; h < lineW + HBL; h++) begin
                vb = (v >= activeLines);
                hb = (h >= lineW);
                if (!vb && !hb && v == skipV && h == skipH) continue;
                vDrawn = (v == originLine && h == 0) ? 0 : v;
                if (rgbInc != 0)  color = 12'(n + 1);
                else if (n < whiteN) color = 12'hfff;
                else              color = 12'h888;
                drivePixel(h, vDrawn, vb, hb, color, (v == rstV && h == rstH));
                if (!vb && !hb) begin
                    expChk = {expChk[14:0], expChk[15]} ^ {4'h0, color};
                    n++;
                    lastPixCycle = cycleCount;
                end
            end
        end
    endtask

    task automatic checkFrame(input string name, input int nFv, input int pix, input logic [15:0] chk,
                              input int seq, input int rng, input int shrt, input int white, input int checkLat);
        checkOutput({name, " frames"}, 32'(fvCount - fvBefore), 32'(nFv));
        if (checkLat != 0)
            checkOutput({name, " latency"}, 32'(fvCycle - lastPixCycle), 32'd2);
        checkOutput({name, " pix@fv"}, 32'(seenPix), 32'(pix));
        checkOutput({name, " pix held"}, 32'(pix_cnt), 32'(pix));
        checkOutput({name, " checksum"}, 32'(checksum), 32'(chk));
        checkOutput({name, " err_seq"}, 32'(err_seq), 32'(seq));
        checkOutput({name, " err_range"}, 32'(err_range), 32'(rng));
        checkOutput({name, " err_short"}, 32'(err_short), 32'(shrt));
        checkOutput({name, " white"}, 32'(white_cnt), 32'(white));
    endtask

    initial begin
        rst = 1'b1;
        hcount_in = '0; vcount_in = '0; rgb_in = '0;
        vblnk_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1; hsync_in = 1'b1;
        setDefaults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("reset pix_cnt", 32'(pix_cnt), 32'd0);
        checkOutput("reset checksum", 32'(checksum), 32'd0);
        checkOutput("reset errors", 32'({err_seq, err_range, err_short}), 32'd0);
        checkOutput("reset white", 32'(white_cnt), 32'd0);
        drivePixel(0, 0, 1'b1, 1'b1, 12'h000, 1'b0);

        // 32 identical pixels of odd popcount: every bit position sees the colour twice, cancelling to zero.
        applyStimulus();
        checkFrame("clean888", 1, 32, 16'h0000, 0, 0, 0, 0, 1);

        rgbInc = 1;
        applyStimulus();
        checkFrame("ramp", 1, 32, expChk, 0, 0, 0, 0, 1);
        setDefaults();

        whiteN = 3;
        applyStimulus();
        checkFrame("white", 1, 32, expChk, 0, 0, 0, 3 * WHITE_EN, 1);
        setDefaults();

        // 31 pixels of 888: rotating 0x0444 left once and XORing 0x888 would reach zero, so 0x0444.
        skipV = 1; skipH = 3;
        applyStimulus();
        checkFrame("skip", 1, 31, 16'h0444, 1, 0, 0, 0, 1);
        setDefaults();

        applyStimulus();
        checkFrame("recover", 1, 32, 16'h0000, 0, 0, 0, 0, 1);

        activeLines = 2;
        applyStimulus();
        checkFrame("short", 1, 16, 16'hFFFF, 0, 0, 1, 0, 0);
        setDefaults();

        extraH = 1;
        applyStimulus();
        checkFrame("range", 1, 33, 16'h0888, 0, 1, 0, 0, 1);
        setDefaults();

        originLine = 2;
        applyStimulus();
        checkFrame("origin", 1, 32, 16'h0000, 1, 0, 0, 0, 1);
        setDefaults();

        rstV = 2; rstH = 4;
        applyStimulus();
        checkOutput("midrst frames", 32'(fvCount - fvBefore), 32'd0);
        checkOutput("midrst pix_cnt", 32'(pix_cnt), 32'd0);
        checkOutput("midrst err_seq", 32'(err_seq), 32'd0);
        setDefaults();

        applyStimulus();
        checkFrame("postrst", 1, 32, 16'h0000, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vga_frame_checker.md
VGA_FRAME_CHECKER -- requirements
Module: vga_frame_checker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 600, meaning active lines per frame.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports vcount_in, hcount_in  input  11 each  VGA pixel coordinates.
REQ-006 SHALL have ports vsync_in, vblnk_in, hsync_in, hblnk_in  input  1 each  VGA timing strobes.
REQ-007 SHALL have port rgb_in  input  12  pixel colour {R[3:0],G[3:0],B[3:0]}, same cycle as coordinates.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse; report outputs valid.
REQ-009 SHALL have port pix_cnt  output  20  active pixels counted in the reported frame.
REQ-010 SHALL have port checksum  output  16  frame checksum.
REQ-011 SHALL have ports err_seq, err_range, err_short  output  1 each  per-frame error flags.
REQ-012 SHALL have port white_cnt  output  20  count of rgb==12'hfff pixels (see Configuration).

Function
REQ-013 SHALL register all inputs in one stage; all checks use the registered copies.
REQ-014 An active pixel SHALL be a sample with vblnk==0 and hblnk==0.
REQ-015 FSM states SHALL be WAIT_FRAME, CAPTURE, REPORT.
REQ-016 WAIT_FRAME -> CAPTURE on an active pixel at (h=0,v=0); that pixel is the first pixel accumulated.
REQ-017 CAPTURE: per active pixel, pix_cnt_acc+1 and chk = {chk[14:0],chk[15]} ^ {4'h0,rgb}; chk starts at 16'h0000.
REQ-018 CAPTURE: err_seq SHALL be set if an active pixel is not (h_prev+1, v_prev) within a line, or not (0, v_prev+1) at line start.
REQ-019 CAPTURE: err_range SHALL be set on an active pixel with h>=H_ACTIVE or v>=V_ACTIVE.
REQ-020 CAPTURE -> REPORT after accumulating the active pixel (H_ACTIVE-1, V_ACTIVE-1).
REQ-021 CAPTURE -> REPORT with err_short=1 on a rising edge of vblnk before that pixel is seen.
REQ-022 REPORT SHALL last one cycle: latch accumulators and flags into outputs, pulse frame_valid, clear accumulators, go to WAIT_FRAME.
REQ-023 Latency: frame_valid SHALL be high in the second cycle after the last pixel is presented on the inputs.
REQ-024 Outputs other than frame_valid SHALL hold their values until the next REPORT.
REQ-025 pix_cnt and white_cnt SHALL saturate at 20'hFFFFF.
REQ-026 An active (0,0) seen during CAPTURE SHALL set err_seq and SHALL NOT restart the frame.

Reset
REQ-027 On rst: state WAIT_FRAME; input stage, accumulators, frame_valid, pix_cnt, checksum, white_cnt and all error flags = 0.
REQ-028 rst mid-frame SHALL discard the partial frame; no frame_valid until the next full frame after reset.

Configuration
REQ-029 With macro FRAME_CHECK_WHITE_CNT_EN defined, white_cnt SHALL count active pixels with rgb==12'hfff per frame.
REQ-030 Without FRAME_CHECK_WHITE_CNT_EN, white_cnt SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-031 Clean 800x600 frame, rgb=12'h888 everywhere -> one frame_valid, pix_cnt=480000, all error flags 0.
REQ-032 Same frame with 27 pixels at 12'hfff, macro defined -> white_cnt=27; macro undefined -> white_cnt=0.
REQ-033 H_ACTIVE=4, V_ACTIVE=2, rgb=1,2,...,8 -> checksum equals the REQ-017 rotate-XOR model value; frame_valid two cycles after pixel (3,1).
REQ-034 Skip hcount 10 on line 5 -> err_seq=1 and pix_cnt=479999 at frame_valid; next clean frame reports err_seq=0.
REQ-035 vblnk rises after line 299 -> frame_valid with err_short=1 and pix_cnt=240000.
REQ-036 rst pulse at pixel (400,300), then one clean frame -> exactly one frame_valid, pix_cnt=480000, no errors.
